// File: rtl/shift_add_mac_pkg.sv
// Shared FSM state encoding and accumulator select codes for the shift-add MAC.
package shift_add_mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    ACC  = 2'd2
  } state_t;

  localparam logic [1:0] SEL_HOLD = 2'd0;
  localparam logic [1:0] SEL_ADD  = 2'd1;
  localparam logic [1:0] SEL_CLR  = 2'd2;

endpackage

// File: rtl/mux_lib.sv
// Library selection cells used for every register-input choice in the MAC datapath.
module Mux2to1 #(
  parameter int W = 1
) (
  input  logic         sel,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic [W-1:0] out
);
  assign out = sel ? in1 : in0;
endmodule

module Mux4to1 #(
  parameter int W = 1
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  output logic [W-1:0] out
);
  always_comb begin
    out = in0;
    case (sel)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      default: out = in3;
    endcase
  end
endmodule

// File: rtl/shift_add_mac_ctrl.sv
// Sequencer for the shift-add MAC: IDLE -> MULT (N steps) -> ACC -> IDLE,
// producing operand load/step strobes, the accumulator select and the done pulse.
module shift_add_mac_ctrl
  import shift_add_mac_pkg::*;
#(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       clr_acc,
  output logic       busy,
  output logic       done,
  output logic       load,
  output logic       step,
  output logic [1:0] acc_sel
);

  localparam int CNT_W = $clog2(N + 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = MULT;
      MULT:    if (cnt == CNT_W'(N - 1)) state_next = ACC;
      ACC:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // start and clr_acc only have an effect while IDLE; everything else ignores them.
  always_comb begin
    busy    = (state != IDLE);
    load    = (state == IDLE) && start;
    step    = (state == MULT);
    acc_sel = SEL_HOLD;
    if (state == ACC)                 acc_sel = SEL_ADD;
    else if (state == IDLE && clr_acc) acc_sel = SEL_CLR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= '0;
    else if (step) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) done <= 1'b0;
    else     done <= (state == ACC);
  end

endmodule

// File: rtl/shift_add_mac.sv
// Sequential unsigned multiply-accumulate: a*b by shift-and-add over N cycles,
// then the 2N-bit product is added into a wrapping ACC_W-bit accumulator.
module shift_add_mac
  import shift_add_mac_pkg::*;
#(
  parameter int N     = 8,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clr_acc,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  logic             load;
  logic             step;
  logic [1:0]       acc_sel;

  logic [2*N-1:0]   mcand, mcand_step, mcand_next;
  logic [N-1:0]     mplier, mplier_step, mplier_next;
  logic [2*N-1:0]   prod, prod_step, prod_next, addend;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_next;

  shift_add_mac_ctrl #(.N(N)) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .clr_acc (clr_acc),
    .busy    (busy),
    .done    (done),
    .load    (load),
    .step    (step),
    .acc_sel (acc_sel)
  );

  Mux2to1 #(.W(2*N)) u_addend (.sel(mplier[0]), .in0('0), .in1(mcand), .out(addend));

  // Each operand register: step (shift/add) first, then load overrides on accept.
  Mux2to1 #(.W(2*N)) u_mcand_step (.sel(step), .in0(mcand), .in1(mcand << 1), .out(mcand_step));
  Mux2to1 #(.W(2*N)) u_mcand_load (.sel(load), .in0(mcand_step), .in1({{N{1'b0}}, a}), .out(mcand_next));

  Mux2to1 #(.W(N)) u_mplier_step (.sel(step), .in0(mplier), .in1(mplier >> 1), .out(mplier_step));
  Mux2to1 #(.W(N)) u_mplier_load (.sel(load), .in0(mplier_step), .in1(b), .out(mplier_next));

  Mux2to1 #(.W(2*N)) u_prod_step (.sel(step), .in0(prod), .in1(prod + addend), .out(prod_step));
  Mux2to1 #(.W(2*N)) u_prod_load (.sel(load), .in0(prod_step), .in1('0), .out(prod_next));

  assign sum = {1'b0, acc} + {{(ACC_W + 1 - 2*N){1'b0}}, prod};

  Mux4to1 #(.W(ACC_W)) u_acc_sel (
    .sel(acc_sel), .in0(acc), .in1(sum[ACC_W-1:0]), .in2('0), .in3('0), .out(acc_next)
  );

  Mux4to1 #(.W(1)) u_ovf_sel (
    .sel(acc_sel), .in0(ovf), .in1(ovf | sum[ACC_W]), .in2(1'b0), .in3(1'b0), .out(ovf_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      acc    <= '0;
      ovf    <= 1'b0;
    end else begin
      mcand  <= mcand_next;
      mplier <= mplier_next;
      prod   <= prod_next;
      acc    <= acc_next;
      ovf    <= ovf_next;
    end
  end

endmodule

// File: tb/tb_shift_add_mac.sv
// Randomized self-checking bench for shift_add_mac against a plain-arithmetic
// accumulate model (acc mod 2^20, sticky overflow).
module tb_shift_add_mac;

  localparam int N     = 8;
  localparam int ACC_W = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             clr_acc = 1'b0;
  logic [N-1:0]     a = '0;
  logic [N-1:0]     b = '0;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] acc;
  logic             ovf;

  int          checks = 0;
  int          errors = 0;
  int unsigned model_acc = 0;
  bit          model_ovf = 1'b0;

  shift_add_mac #(.N(N), .ACC_W(ACC_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .clr_acc (clr_acc),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .acc     (acc),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Reference: unsigned product added into a 2^ACC_W wrapping accumulator.
  task automatic modelOp(input int unsigned op_a, input int unsigned op_b, input bit clr);
    int unsigned total;
    if (clr) begin
      model_acc = 0;
      model_ovf = 1'b0;
    end
    total = model_acc + op_a * op_b;
    if (total >= (1 << ACC_W)) model_ovf = 1'b1;
    model_acc = total % (1 << ACC_W);
  endtask

  // Returns at #1 after the edge on which done was first seen, so a following
  // call drives start inside the done cycle.
  task automatic applyStimulus(input logic [N-1:0] op_a, input logic [N-1:0] op_b,
                               input bit clr, input bit noise);
    int seen;
    seen = 0;
    @(negedge clk);
    a = op_a; b = op_b; start = 1'b1; clr_acc = clr;
    @(posedge clk); #1;
    start = 1'b0; clr_acc = 1'b0;
    modelOp(op_a, op_b, clr);
    checkOutput("busy_accept", busy, 1);
    for (int i = 1; i <= 20 && seen == 0; i++) begin
      if (noise && i >= 2 && i <= 6) begin
        a = N'($urandom); b = N'($urandom);
        start = 1'($urandom); clr_acc = 1'($urandom);
      end else begin
        start = 1'b0; clr_acc = 1'b0;
      end
      @(posedge clk); #1;
      if (done) seen = i;
      else if (busy !== 1'b1) checkOutput("busy_during_op", busy, 1);
    end
    checkOutput("done_latency", seen, N + 1);
    checkOutput("busy_after_done", busy, 0);
    checkOutput("acc", acc, model_acc);
    checkOutput("ovf", ovf, model_ovf);
  endtask

  task automatic clearAcc();
    @(negedge clk);
    clr_acc = 1'b1;
    @(posedge clk); #1;
    clr_acc = 1'b0;
    model_acc = 0;
    model_ovf = 1'b0;
    checkOutput("clr_acc", acc, 0);
    checkOutput("clr_ovf", ovf, 0);
    checkOutput("clr_busy", busy, 0);
  endtask

  initial begin
    int unsigned saved;
    int dones;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_acc", acc, 0);
    checkOutput("rst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(8'd3, 8'd5, 1'b0, 1'b0);
    checkOutput("t1_acc_const", acc, 15);
    @(posedge clk); #1;
    checkOutput("done_width", done, 0);

    applyStimulus(8'd255, 8'd255, 1'b0, 1'b0);
    checkOutput("t2_acc_const", acc, 65040);

    applyStimulus(8'd2, 8'd7, 1'b1, 1'b0);
    checkOutput("t3_acc_const", acc, 14);

    clearAcc();
    repeat (17) applyStimulus(8'd255, 8'd255, 1'b0, 1'b0);
    checkOutput("t4_acc_const", acc, 56849);
    checkOutput("t4_ovf_const", ovf, 1);
    clearAcc();

    applyStimulus(N'($urandom), N'($urandom), 1'b0, 1'b1);
    applyStimulus(8'd9, 8'd9, 1'b0, 1'b1);

    // Abort in the middle of MULT: no done may follow.
    @(negedge clk);
    a = 8'd50; b = 8'd60; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    model_acc = 0;
    model_ovf = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_acc", acc, model_acc);
    checkOutput("abort_ovf", ovf, model_ovf);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    checkOutput("abort_no_done", dones, 0);

    applyStimulus(8'd123, 8'd45, 1'b0, 1'b0);
    saved = model_acc;
    applyStimulus(8'd0, 8'd200, 1'b0, 1'b0);
    checkOutput("zero_unchanged", acc, saved);
    applyStimulus(8'd1, 8'd1, 1'b0, 1'b0);
    checkOutput("back_to_back", acc, saved + 1);

    for (int k = 0; k < 12; k++)
      applyStimulus(N'($urandom), N'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
